// File: rtl/capture_ctrl.sv
// Capture controller: pre/post-trigger ring buffer with normal/auto/single modes and strobed readout.
// A record is always DEPTH samples, with the trigger sample at index pre_q.
module capture_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 12,
  parameter int AUTO_W = 16
) (
  input  logic              adc_dco,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              sample_en,
  input  logic              trig_in,
  input  logic              arm,
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] pre_len,
  input  logic [AUTO_W-1:0] auto_timeout,
  input  logic              host_rdy,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              rd_last,
  output logic              busy,
  output logic              triggered,
  output logic              forced,
  output logic [ADDR_W-1:0] trig_addr
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_ARMED, S_POST, S_DONE, S_READ} state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] pre_q, wr_ptr, rd_ptr, cnt, post_rem, rd_cnt;
  logic [1:0]        mode_q;
  logic [AUTO_W-1:0] auto_cnt;
  logic              is_single, is_auto;
  logic              start_acq, finish, restart, wr_en, trig_hit, trig_forced, rd_fire, load_rd;

  // Mode 3 decodes as single along with mode 2.
  assign is_single = mode_q[1];
  assign is_auto   = (mode_q == 2'd1);
  assign restart   = finish && !is_single;
  assign busy      = (state != S_IDLE);

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no latch can be inferred.
    state_nxt   = state;
    start_acq   = 1'b0;
    finish      = 1'b0;
    wr_en       = 1'b0;
    trig_hit    = 1'b0;
    trig_forced = 1'b0;
    rd_fire     = 1'b0;
    load_rd     = 1'b0;
    case (state)
      // pre_len is ADDR_W bits wide, so it can never exceed DEPTH-1 and needs no clamp.
      S_IDLE: if (arm) begin
        start_acq = 1'b1;
        state_nxt = (pre_len == '0) ? S_ARMED : S_PRE;
      end
      S_PRE: if (sample_en) begin
        wr_en = 1'b1;
        if (cnt + ADDR_W'(1) == pre_q) state_nxt = S_ARMED;
      end
      S_ARMED: if (sample_en) begin
        wr_en = 1'b1;
        if (trig_in) begin
          trig_hit = 1'b1;
        end else if (is_auto && auto_cnt == auto_timeout) begin
          trig_hit    = 1'b1;
          trig_forced = 1'b1;
        end
        // With pre_q = DEPTH-1 the trigger sample completes the record.
        if (trig_hit) state_nxt = (pre_q == '1) ? S_DONE : S_POST;
      end
      S_POST: if (sample_en) begin
        wr_en = 1'b1;
        if (post_rem == ADDR_W'(1)) state_nxt = S_DONE;
      end
      S_DONE: if (host_rdy) begin
        load_rd   = 1'b1;
        state_nxt = S_READ;
      end
      S_READ: if (!host_rdy) begin
        finish = 1'b1;
      end else if (rd_en) begin
        rd_fire = 1'b1;
        finish  = (rd_cnt == '1);
      end
      default: state_nxt = S_IDLE;
    endcase
    if (finish) state_nxt = is_single ? S_IDLE : ((pre_q == '0) ? S_ARMED : S_PRE);
  end

  always_ff @(posedge adc_dco) begin
    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge adc_dco) begin
    if (!rst_n) begin
      pre_q     <= '0;
      mode_q    <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cnt       <= '0;
      post_rem  <= '0;
      rd_cnt    <= '0;
      auto_cnt  <= '0;
      trig_addr <= '0;
      triggered <= 1'b0;
      forced    <= 1'b0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
      rd_last   <= 1'b0;
    end else begin
      rd_valid <= rd_fire;
      rd_last  <= rd_fire && (rd_cnt == '1);
      if (start_acq) begin
        pre_q  <= pre_len;
        mode_q <= mode;
      end
      if (start_acq || restart) begin
        wr_ptr   <= '0;
        cnt      <= '0;
        auto_cnt <= '0;
        forced   <= 1'b0;
      end
      if (finish) triggered <= 1'b0;
      if (wr_en) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (wr_en && state == S_PRE) cnt <= cnt + ADDR_W'(1);
      if (wr_en && state == S_ARMED && !trig_hit && is_auto) auto_cnt <= auto_cnt + AUTO_W'(1);
      if (wr_en && state == S_POST) post_rem <= post_rem - ADDR_W'(1);
      // Post count DEPTH-1-pre_q equals ~pre_q in ADDR_W bits.
      if (trig_hit) begin
        trig_addr <= wr_ptr;
        triggered <= 1'b1;
        forced    <= trig_forced;
        post_rem  <= ~pre_q;
      end
      if (load_rd) begin
        rd_ptr <= trig_addr - pre_q;
        rd_cnt <= '0;
      end
      if (rd_fire) begin
        rd_data <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + ADDR_W'(1);
        rd_cnt  <= rd_cnt + ADDR_W'(1);
      end
    end
  end

  // NOTE: the sample array has no reset; only the control path is cleared.
  always_ff @(posedge adc_dco) begin
    if (rst_n && wr_en) mem[wr_ptr] <= sample_in;
  end

endmodule

// File: tb/tb_capture_ctrl.sv
// Randomised bench for capture_ctrl: a sample-history model derives each record, trigger index and readout.
module tb_capture_ctrl;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;
  localparam int AUTO_W = 16;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              adc_dco = 1'b0;
  logic              rst_n;
  logic [DATA_W-1:0] sample_in;
  logic              sample_en, trig_in, arm, host_rdy, rd_en;
  logic [1:0]        mode;
  logic [ADDR_W-1:0] pre_len;
  logic [AUTO_W-1:0] auto_timeout;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid, rd_last, busy, triggered, forced;
  logic [ADDR_W-1:0] trig_addr;

  capture_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .AUTO_W(AUTO_W)) dut (
    .adc_dco(adc_dco), .rst_n(rst_n), .sample_in(sample_in), .sample_en(sample_en),
    .trig_in(trig_in), .arm(arm), .mode(mode), .pre_len(pre_len),
    .auto_timeout(auto_timeout), .host_rdy(host_rdy), .rd_en(rd_en),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_last(rd_last), .busy(busy),
    .triggered(triggered), .forced(forced), .trig_addr(trig_addr)
  );

  always #5 adc_dco = ~adc_dco;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge adc_dco);
    #1;
  endtask

  task automatic check_cleared(input string ctx);
    check({ctx, "_rd_data"},   32'(rd_data),   0);
    check({ctx, "_rd_valid"},  32'(rd_valid),  0);
    check({ctx, "_rd_last"},   32'(rd_last),   0);
    check({ctx, "_busy"},      32'(busy),      0);
    check({ctx, "_triggered"}, 32'(triggered), 0);
    check({ctx, "_forced"},    32'(forced),    0);
    check({ctx, "_trig_addr"}, 32'(trig_addr), 0);
  endtask

  // Arm with a coincident qualified trigger, which must be ignored.
  task automatic do_arm(input int md, input int pre);
    mode      = 2'(md);
    pre_len   = ADDR_W'(pre);
    arm       = 1'b1;
    sample_en = 1'b1;
    trig_in   = 1'b1;
    sample_in = DATA_W'($urandom);
    rd_en     = 1'b0;
    host_rdy  = 1'b0;
    step();
    arm       = 1'b0;
    sample_en = 1'b0;
    trig_in   = 1'b0;
    check("arm_busy", 32'(busy), 1);
    check("arm_triggered", 32'(triggered), 0);
  endtask

  // One record from a freshly (re-)armed controller: capture, DONE, readout, finish.
  task automatic run_record(input int md, input int pre, input int plan, input int ato,
                            input bit ramp, input int first_val, input int abort_after);
    int n, t, cyc, k, nrd, bad_busy, bad_rdv;
    bit frc;
    logic [DATA_W-1:0] hist [$];
    logic [DATA_W-1:0] rec [DEPTH];
    n = 0; t = -1; cyc = 0; bad_busy = 0; bad_rdv = 0; frc = 1'b0;
    auto_timeout = AUTO_W'(ato);
    host_rdy = 1'b0;
    while (!(t >= 0 && n == t + DEPTH - pre)) begin
      if (cyc++ > 4000) begin
        check("capture_bound", 1, 0);
        return;
      end
      sample_en = ramp ? 1'b1 : ($urandom_range(0, 3) != 0);
      sample_in = ramp ? DATA_W'(n) : DATA_W'($urandom);
      if (n == 0 && first_val >= 0) sample_in = DATA_W'(first_val);
      if (t < 0 && n == plan) trig_in = sample_en;
      else if (n < pre || !sample_en || t >= 0) trig_in = 1'($urandom_range(0, 1));
      else trig_in = 1'b0;
      arm     = ($urandom_range(0, 15) == 0);
      mode    = 2'($urandom);
      pre_len = ADDR_W'($urandom);
      rd_en   = 1'($urandom_range(0, 1));
      if (sample_en) begin
        if (t < 0 && n >= pre) begin
          if (trig_in) begin
            t = n; frc = 1'b0;
          end else if (md == 1 && n - pre == ato) begin
            t = n; frc = 1'b1;
          end
        end
        hist.push_back(sample_in);
        n++;
      end
      step();
      if (!busy) bad_busy++;
      if (rd_valid) bad_rdv++;
    end
    arm = 1'b0; trig_in = 1'b0; rd_en = 1'b0;
    check("capture_busy", 32'(bad_busy), 0);
    check("capture_rd_valid", 32'(bad_rdv), 0);
    check("triggered", 32'(triggered), 1);
    check("forced", 32'(frc), 32'(forced) ^ 32'(frc) ^ 32'(frc) == 32'(forced) ? 32'(forced) : 32'(forced));
    check("trig_addr", 32'(trig_addr), 32'(t % DEPTH));
    for (int i = 0; i < DEPTH; i++) rec[i] = hist[t - pre + i];

    // Samples arriving in DONE must not land in the ring.
    repeat ($urandom_range(1, 3)) begin
      sample_en = 1'b1;
      sample_in = DATA_W'($urandom);
      step();
    end
    sample_en = 1'b0;
    host_rdy  = 1'b1;
    step();

    k = 0; cyc = 0;
    nrd = (abort_after >= 0) ? abort_after : DEPTH;
    while (k < nrd) begin
      if (cyc++ > 200) begin
        check("read_bound", 1, 0);
        break;
      end
      rd_en     = ($urandom_range(0, 2) != 0);
      sample_en = 1'($urandom_range(0, 1));
      sample_in = DATA_W'($urandom);
      step();
      if (rd_en) begin
        check($sformatf("rd_valid[%0d]", k), 32'(rd_valid), 1);
        check($sformatf("rd_data[%0d]", k), 32'(rd_data), 32'(rec[k]));
        check($sformatf("rd_last[%0d]", k), 32'(rd_last), 32'(k == DEPTH - 1));
        k++;
      end else begin
        check("rd_idle", 32'(rd_valid), 0);
      end
    end
    sample_en = 1'b0;
    if (abort_after >= 0) begin
      host_rdy = 1'b0;
      rd_en    = 1'b1;
      step();
      check("abort_rd_valid", 32'(rd_valid), 0);
    end
    rd_en = 1'b0;
    check("end_busy", 32'(busy), 32'(md < 2));
    check("end_triggered", 32'(triggered), 0);
    check("end_forced", 32'(forced), 0);
    if (abort_after >= 0) begin
      bad_rdv = 0;
      rd_en = 1'b1;
      repeat (3) begin
        step();
        if (rd_valid) bad_rdv++;
      end
      rd_en = 1'b0;
      check("abort_no_reads", 32'(bad_rdv), 0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int pre, md, ab;
    rst_n = 1'b0; sample_in = '0; sample_en = 1'b0; trig_in = 1'b0; arm = 1'b0;
    mode = '0; pre_len = '0; auto_timeout = '0; host_rdy = 1'b0; rd_en = 1'b0;
    repeat (3) step();
    check_cleared("reset");
    rst_n = 1'b1;
    step();
    check("idle_busy", 32'(busy), 0);

    // Normal mode: ramp record, random record, aborted record; each re-arms.
    do_arm(0, 4);
    run_record(0, 4, 10, 0, 1'b1, -1, -1);
    run_record(0, 4, 4 + int'($urandom_range(0, 20)), 0, 1'b0, -1, -1);
    run_record(0, 4, 8, 0, 1'b0, -1, 5);

    // Reset while in POST of the re-armed record.
    sample_en = 1'b1;
    trig_in   = 1'b1;
    for (int i = 0; i < 7; i++) begin
      sample_in = DATA_W'($urandom);
      step();
    end
    sample_en = 1'b0;
    trig_in   = 1'b0;
    check("post_triggered", 32'(triggered), 1);
    rst_n = 1'b0;
    step();
    check_cleared("post_reset");
    rst_n = 1'b1;
    step();

    // Single, no pre-trigger samples, trigger on the first sample.
    do_arm(2, 0);
    run_record(2, 0, 0, 0, 1'b0, 8'h55, -1);

    // Auto: forced record, real-trigger record, zero-timeout record.
    do_arm(1, 3);
    run_record(1, 3, -1, 5, 1'b0, -1, -1);
    run_record(1, 3, 4, 5, 1'b0, -1, -1);
    run_record(1, 3, -1, 0, 1'b0, -1, -1);
    rst_n = 1'b0;
    step();
    check("auto_reset_busy", 32'(busy), 0);
    rst_n = 1'b1;
    step();

    // Maximum pre length with ring wrap before the trigger; mode 3 with abort.
    do_arm(2, 15);
    run_record(2, 15, 20, 0, 1'b0, -1, -1);
    do_arm(3, 6);
    run_record(3, 6, 9, 0, 1'b0, -1, 3);

    for (int i = 0; i < 6; i++) begin
      pre = int'($urandom_range(0, DEPTH - 1));
      md  = int'($urandom_range(2, 3));
      ab  = ($urandom_range(0, 1) != 0) ? -1 : int'($urandom_range(1, DEPTH - 1));
      do_arm(md, pre);
      run_record(md, pre, pre + int'($urandom_range(0, 24)), 0, 1'b0, -1, ab);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
